// File: rtl/barrel_shifter_seq.sv
// Sequential barrel shifter. It shifts one bit position per cycle through a
// working register. A request is taken in IDLE and shifted in SHIFT for s
// cycles. The registered result is held in DONE until the consumer accepts it.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset
//   req_valid_in  request present         req_ready_out  accepting (IDLE only)
//   x_in          operand                 s_in           shift amount
//   op_in         000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR,
//                 11x pass-through
//   rsp_valid_out result valid (DONE)     rsp_ready_in   consumer accepts
//   y_out         result                  zf_out         y_out == 0
//   vf_out        ASL overflow            busy_out       in SHIFT or DONE
module barrel_shifter_seq #(
  parameter int D_SIZE = 4,
  localparam int SW = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [SW-1:0]     s_in,
  input  logic [2:0]        op_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out,
  output logic              busy_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [D_SIZE-1:0] work, step_w;
  logic [SW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              vf_acc, step_vf;
  logic              accept, needs_shift, last_step;

  assign accept      = req_valid_in && req_ready_out;
  // Zero shifts and the pass-through codes skip SHIFT entirely.
  assign needs_shift = (s_in != '0) && (op_in <= 3'd5);
  assign last_step   = (cnt == SW'(1));

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = needs_shift ? SHIFT : DONE;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (rsp_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. Ready is masked by reset so nothing is taken while it is asserted.
  always_comb begin
    req_ready_out = (state == IDLE) && !rst_in;
    rsp_valid_out = (state == DONE);
    busy_out      = (state != IDLE);
  end

  // A single-bit step of the working register.
  always_comb begin
    step_w = work;
    unique case (op_q)
      3'b000, 3'b010: step_w = {work[D_SIZE-2:0], 1'b0};
      3'b001:         step_w = {1'b0, work[D_SIZE-1:1]};
      3'b011:         step_w = {work[D_SIZE-1], work[D_SIZE-1:1]};
      3'b100:         step_w = {work[D_SIZE-2:0], work[D_SIZE-1]};
      3'b101:         step_w = {work[0], work[D_SIZE-1:1]};
      default:        step_w = work;
    endcase
    // ASL overflows when the sign bit is about to change.
    step_vf = vf_acc | ((op_q == 3'b010) && (work[D_SIZE-1] != work[D_SIZE-2]));
  end

  // Datapath. The result registers load only when DONE is entered, so they
  // stay stable while a response is stalled.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      work   <= '0;
      cnt    <= '0;
      op_q   <= '0;
      vf_acc <= 1'b0;
      y_out  <= '0;
      zf_out <= 1'b0;
      vf_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          work   <= x_in;
          cnt    <= s_in;
          op_q   <= op_in;
          vf_acc <= 1'b0;
          if (!needs_shift) begin
            y_out  <= x_in;
            zf_out <= (x_in == '0);
            vf_out <= 1'b0;
          end
        end
        SHIFT: begin
          work   <= step_w;
          cnt    <= cnt - SW'(1);
          vf_acc <= step_vf;
          if (last_step) begin
            y_out  <= step_w;
            zf_out <= (step_w == '0);
            vf_out <= step_vf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shifter_seq.sv
module tb_barrel_shifter_seq;
  localparam int D  = 4;
  localparam int SW = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [D-1:0]  x_in = '0;
  logic [SW-1:0] s_in = '0;
  logic [2:0]    op_in = '0;
  logic          rsp_valid_out;
  logic          rsp_ready_in = 1'b0;
  logic [D-1:0]  y_out;
  logic          zf_out, vf_out, busy_out;

  int tests = 0;
  int fails = 0;

  barrel_shifter_seq #(.D_SIZE(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .x_in(x_in), .s_in(s_in), .op_in(op_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .y_out(y_out), .zf_out(zf_out), .vf_out(vf_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]    op;
    logic [D-1:0]  x;
    logic [SW-1:0] s;
    logic [D-1:0]  y;
    logic          zf;
    logic          vf;
    int            lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op definitions.
  function automatic void ref_model(input logic [2:0] op, input logic [D-1:0] x,
                                    input int s, output logic [D-1:0] y,
                                    output logic vf, output int lat);
    int mask, xi, top;
    logic signed [D-1:0] xs;
    mask = (1 << D) - 1;
    xi   = int'(x);
    xs   = x;
    vf   = 1'b0;
    case (op)
      3'd0, 3'd2: y = D'((xi << s) & mask);
      3'd1:       y = D'(xi >> s);
      3'd3:       y = D'(xs >>> s);
      3'd4:       y = D'(((xi << s) | (xi >> (D - s))) & mask);
      3'd5:       y = D'(((xi >> s) | (xi << (D - s))) & mask);
      default:    y = x;
    endcase
    if (op == 3'd2) begin
      // Overflow iff the top s+1 bits are not all equal.
      top = xi >> (D - 1 - s);
      vf  = !(top == 0 || top == ((1 << (s + 1)) - 1));
    end
    lat = (op <= 3'd5 && s != 0) ? s + 1 : 1;
  endfunction

  // Issues one request, measures latency, checks the result, stalls, then
  // completes the handshake. With scramble set, request inputs are randomised
  // while the block is busy.
  task automatic do_req(input string tag, input vec_t v, input int stall, input bit scramble);
    int lat;
    bit ok;
    @(negedge clk_in);
    chk({tag, " ready"}, int'(req_ready_out), 1);
    req_valid_in = 1'b1; op_in = v.op; x_in = v.x; s_in = v.s;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = scramble ? 1'($urandom) : 1'b0;
    if (scramble) begin x_in = D'($urandom); s_in = SW'($urandom); op_in = 3'($urandom); end
    lat = 1;
    while (!rsp_valid_out && lat < 40) begin
      @(negedge clk_in);
      lat++;
      if (scramble) begin
        req_valid_in = 1'($urandom); x_in = D'($urandom); s_in = SW'($urandom); op_in = 3'($urandom);
      end
    end
    chk({tag, " lat"}, lat, v.lat);
    chk({tag, " y"},  int'(y_out),  int'(v.y));
    chk({tag, " zf"}, int'(zf_out), int'(v.zf));
    chk({tag, " vf"}, int'(vf_out), int'(v.vf));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_in);
      if (scramble) begin x_in = D'($urandom); op_in = 3'($urandom); end
      ok = rsp_valid_out && !req_ready_out && y_out == v.y && zf_out == v.zf && vf_out == v.vf;
      chk({tag, " stall"}, int'(ok), 1);
    end
    req_valid_in = 1'b0;
    rsp_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rsp_ready_in = 1'b0;
    chk({tag, " idle"}, int'(busy_out), 0);
  endtask

  vec_t tbl[9];
  vec_t v;
  int   rlat, quiet;
  logic [D-1:0] ry;
  logic rvf;

  initial begin
    tbl[0] = '{3'b000, 4'b0011, 2'd2, 4'b1100, 1'b0, 1'b0, 3};
    tbl[1] = '{3'b010, 4'b0011, 2'd2, 4'b1100, 1'b0, 1'b1, 3};
    tbl[2] = '{3'b011, 4'b1000, 2'd3, 4'b1111, 1'b0, 1'b0, 4};
    tbl[3] = '{3'b001, 4'b0100, 2'd3, 4'b0000, 1'b1, 1'b0, 4};
    tbl[4] = '{3'b100, 4'b1001, 2'd0, 4'b1001, 1'b0, 1'b0, 1};
    tbl[5] = '{3'b101, 4'b0001, 2'd1, 4'b1000, 1'b0, 1'b0, 2};
    tbl[6] = '{3'b110, 4'b0000, 2'd3, 4'b0000, 1'b1, 1'b0, 1};
    tbl[7] = '{3'b010, 4'b1100, 2'd1, 4'b1000, 1'b0, 1'b0, 2};
    tbl[8] = '{3'b010, 4'b0110, 2'd2, 4'b1000, 1'b0, 1'b1, 3};

    // Reset and release
    repeat (2) @(negedge clk_in);
    chk("rst ready low", int'(req_ready_out), 0);
    chk("rst busy", int'(busy_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rel ready", int'(req_ready_out), 1);
    chk("rel valid", int'(rsp_valid_out), 0);
    chk("rel y", int'(y_out), 0);
    chk("rel zf", int'(zf_out), 0);
    chk("rel vf", int'(vf_out), 0);

    // Directed table. The first vector also gets the 5-cycle stall.
    foreach (tbl[i])
      do_req($sformatf("vec%0d", i), tbl[i], (i == 0) ? 5 : 0, 1'b0);

    // Reset asserted mid-SHIFT: no response and IDLE on the next cycle
    @(negedge clk_in);
    req_valid_in = 1'b1; op_in = 3'b000; x_in = 4'b0011; s_in = 2'd3;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 1'b0;
    chk("mid busy", int'(busy_out), 1);
    rst_in = 1'b1;
    rsp_ready_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("mid abort busy", int'(busy_out), 0);
    chk("mid abort valid", int'(rsp_valid_out), 0);
    chk("mid abort y", int'(y_out), 0);
    rst_in = 1'b0;
    rsp_ready_in = 1'b0;
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (rsp_valid_out || !req_ready_out) quiet = 0;
    end
    chk("mid no response", quiet, 1);

    // Exhaustive sweep against the reference with random stalls and input noise
    for (int op = 0; op < 8; op++)
      for (int x = 0; x < 16; x++)
        for (int s = 0; s < 4; s++) begin
          ref_model(3'(op), 4'(x), s, ry, rvf, rlat);
          v = '{3'(op), 4'(x), 2'(s), ry, (ry == '0), rvf, rlat};
          do_req($sformatf("sweep op%0d x%0h s%0d", op, x, s), v, $urandom_range(0, 3), 1'b1);
        end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end
endmodule
